keypad_entry: RTL

Debounced multi-digit keypad entry stage directly downstream of the keypad scanner/decoder. It takes the scanner's 4-bit key code and key-valid level and synchronises and debounces them. It turns each qualified press into one edit action (digit, backspace, clear, enter) on a BCD entry buffer, then presents the finished operand to the FP adder/LCD control with a valid/ack handshake.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_entry_if.sv | 42 ++++
 rtl/key_debounce.sv | 146 ++++++++++++++
 rtl/keypad_entry.sv | 118 +++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad entry stage.
//   KEY_BKSP / KEY_CLR / KEY_ENT : edit key codes coming from the decoder;
//                                  codes 0x0-0x9 are digits, 0xD-0xF do nothing
//   keyState_t                   : states of the press/release qualifier
//   keyCntWidth()                : width of the saturating stability counter
//   digitCountWidth()            : width of the digit count for a buffer size
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;
    localparam logic [3:0] KEY_ENT  = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_QUAL,
        ST_HELD,
        ST_REL_QUAL,
        ST_DONE
    } keyState_t;

    // The counter has to hold the value STABLE_CYCLES itself, hence the +1.
    function automatic int keyCntWidth(input int stableCycles);
        return $clog2(stableCycles + 1);
    endfunction

    function automatic int digitCountWidth(input int maxDigits);
        return $clog2(maxDigits + 1);
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// ---------------------------------------------------------------------------
// keypad_entry_if
// Operand handshake between the keypad entry stage and its consumer
// (FP adder / LCD control).
//   digits      : BCD buffer, least significant digit in [3:0]
//   digitCount  : number of digits currently entered
//   overflow    : sticky, a digit was dropped because the buffer was full
//   numValid    : entry complete, digits/digitCount frozen while high
//   numAck      : consumer accepted the number
// master = keypad entry stage, slave = consumer.
// ---------------------------------------------------------------------------
interface keypad_entry_if
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS = 5
);

    localparam int COUNT_W = digitCountWidth(MAX_DIGITS);

    logic [4*MAX_DIGITS-1:0] digits;
    logic [COUNT_W-1:0]      digitCount;
    logic                    overflow;
    logic                    numValid;
    logic                    numAck;

    modport master (
        output digits,
        output digitCount,
        output overflow,
        output numValid,
        input  numAck
    );

    modport slave (
        input  digits,
        input  digitCount,
        input  overflow,
        input  numValid,
        output numAck
    );

endinterface

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises the decoder's key code / key-valid level into the clk domain
// and qualifies presses and releases: a press must be seen with the same code
// for STABLE_CYCLES consecutive samples, a release for STABLE_CYCLES
// consecutive idle samples. Each qualified press yields exactly one strobe.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   i_keyValue    : raw key code (asynchronous)
//   i_keyValid    : raw key pressed level (asynchronous)
//   i_enterLock   : the press now qualifying parks the stage in DONE
//   i_ack         : consumer acknowledge, leaves DONE
//   o_press       : one-cycle strobe, a press has just qualified
//   o_code        : code of the qualified press (valid with o_press)
//   o_done        : stage is in DONE, keys ignored
// ---------------------------------------------------------------------------
module key_debounce
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_keyValue,
    input  logic       i_keyValid,
    input  logic       i_enterLock,
    input  logic       i_ack,
    output logic       o_press,
    output logic [3:0] o_code,
    output logic       o_done
);

    localparam int               CNT_W      = keyCntWidth(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             r_kvMeta;
    logic             r_kvSync;
    logic [3:0]       r_kcMeta;
    logic [3:0]       r_kcSync;
    keyState_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_cand;

    keyState_t        w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_cntInc;
    logic [3:0]       w_candNext;
    logic             w_press;

    // Two-flop synchronisers for the key-valid level and the key code. The
    // code bits may resolve on different cycles, but a torn code only restarts
    // press qualification, so no gray coding is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kvMeta <= 1'b0;
            r_kvSync <= 1'b0;
            r_kcMeta <= 4'h0;
            r_kcSync <= 4'h0;
        end else begin
            r_kvMeta <= i_keyValid;
            r_kvSync <= r_kvMeta;
            r_kcMeta <= i_keyValue;
            r_kcSync <= r_kcMeta;
        end
    end

    // Qualifier state, stability counter and candidate code registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'h0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_cand  <= w_candNext;
        end
    end

    // Saturating increment so a stuck state can never wrap the counter.
    assign w_cntInc = (r_cnt >= STABLE_VAL) ? STABLE_VAL : (r_cnt + CNT_ONE);

    // Next-state logic. The press strobe is combinational so the action lands
    // on the same edge that takes the STABLE_CYCLES-th matching sample.
    // A qualified enter with a non-empty buffer parks in DONE; from DONE the
    // acknowledge goes to HELD so the key must be seen released first.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_candNext  = r_cand;
        w_press     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_kvSync) begin
                    w_candNext  = r_kcSync;
                    w_cntNext   = CNT_ONE;
                    w_stateNext = ST_PRESS_QUAL;
                end
            end
            ST_PRESS_QUAL: begin
                if (!r_kvSync) begin
                    w_stateNext = ST_IDLE;
                end else if (r_kcSync != r_cand) begin
                    w_candNext = r_kcSync;
                    w_cntNext  = CNT_ONE;
                end else begin
                    w_cntNext = w_cntInc;
                    if (w_cntInc >= STABLE_VAL) begin
                        w_press     = 1'b1;
                        w_stateNext = i_enterLock ? ST_DONE : ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (!r_kvSync) begin
                    w_cntNext   = CNT_ONE;
                    w_stateNext = ST_REL_QUAL;
                end
            end
            ST_REL_QUAL: begin
                if (r_kvSync) begin
                    w_stateNext = ST_HELD;
                end else begin
                    w_cntNext = w_cntInc;
                    if (w_cntInc >= STABLE_VAL) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (i_ack) begin
                    w_stateNext = ST_HELD;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign o_press = w_press;
    assign o_code  = r_cand;
    assign o_done  = (r_state == ST_DONE);

endmodule

// File: rtl/keypad_entry.sv
// ---------------------------------------------------------------------------
// keypad_entry
// Debounced multi-digit keypad entry. Each qualified key press performs one
// edit on a BCD buffer (digit, backspace, clear, enter); enter presents the
// finished operand to the consumer with a valid/ack handshake.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   i_keyValue  : key code from the scanner/decoder (asynchronous)
//   i_keyValid  : key pressed and decoded (asynchronous)
//   o_numIf     : operand handshake (digits, digitCount, overflow,
//                 numValid out; numAck in)
// ---------------------------------------------------------------------------
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS    = 5,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     i_keyValue,
    input  logic           i_keyValid,
    keypad_entry_if.master o_numIf
);

    localparam int                 COUNT_W    = digitCountWidth(MAX_DIGITS);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(MAX_DIGITS);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    logic [4*MAX_DIGITS-1:0] r_digits;
    logic [COUNT_W-1:0]      r_count;
    logic                    r_overflow;

    logic [4*MAX_DIGITS-1:0] w_digitsNext;
    logic [COUNT_W-1:0]      w_countNext;
    logic                    w_overflowNext;
    logic                    w_press;
    logic [3:0]              w_code;
    logic                    w_done;
    logic                    w_enterLock;

    // Enter only completes the entry when there is something to hand over.
    assign w_enterLock = (w_code == KEY_ENT) && (r_count != '0);

    key_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .i_keyValue  (i_keyValue),
        .i_keyValid  (i_keyValid),
        .i_enterLock (w_enterLock),
        .i_ack       (o_numIf.numAck),
        .o_press     (w_press),
        .o_code      (w_code),
        .o_done      (w_done)
    );

    // Buffer edit decode. The acknowledge in DONE empties the buffer for the
    // next operand; otherwise a press strobe applies exactly one edit.
    // Presses cannot qualify while in DONE, so the two never coincide.
    always_comb begin
        w_digitsNext   = r_digits;
        w_countNext    = r_count;
        w_overflowNext = r_overflow;
        if (w_done && o_numIf.numAck) begin
            w_digitsNext   = '0;
            w_countNext    = '0;
            w_overflowNext = 1'b0;
        end else if (w_press) begin
            case (w_code)
                KEY_BKSP: begin
                    if (r_count != '0) begin
                        w_digitsNext = {4'h0, r_digits[4*MAX_DIGITS-1:4]};
                        w_countNext  = r_count - COUNT_ONE;
                    end
                end
                KEY_CLR: begin
                    w_digitsNext   = '0;
                    w_countNext    = '0;
                    w_overflowNext = 1'b0;
                end
                KEY_ENT: begin
                    w_countNext = r_count;
                end
                default: begin
                    if (w_code <= 4'h9) begin
                        if (r_count < COUNT_FULL) begin
                            w_digitsNext = {r_digits[4*MAX_DIGITS-5:0], w_code};
                            w_countNext  = r_count + COUNT_ONE;
                        end else begin
                            w_overflowNext = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Buffer registers; reset discards any partial entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_digits   <= w_digitsNext;
            r_count    <= w_countNext;
            r_overflow <= w_overflowNext;
        end
    end

    assign o_numIf.digits     = r_digits;
    assign o_numIf.digitCount = r_count;
    assign o_numIf.overflow   = r_overflow;
    assign o_numIf.numValid   = w_done;

endmodule
